// File: rtl/kan_pkg.sv
// Shared widths, pipeline control struct and output quantisation helpers for the KAN MAC engine.
// Pure declarations: no latency, no flow control.
// Backpressure is handled by the modules that import this package.
package kan_pkg;

    localparam int KAN_DATA_W       = 16;
    localparam int KAN_COEF_W       = 16;
    localparam int KAN_LANES        = 4;
    localparam int KAN_ACC_W        = 40;
    localparam int KAN_OUT_W        = 16;
    localparam int KAN_LG_LAYERSIZE = 12;
    localparam int KAN_SHIFT_W      = 6;

    // Quantisation is done at a fixed wide width, so any ACC_W below 64 fits without loss.
    localparam int KAN_MAX_W = 64;

    typedef logic signed [KAN_MAX_W:0] kan_wide_t;

    typedef struct packed {
        logic       first;
        logic       fin;
        logic       tlast;
        logic [7:0] shift;
    } kan_ctl_t;

    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

    function automatic kan_wide_t kan_round_shift(input logic [KAN_MAX_W-1:0] sum,
                                                  input logic [7:0] shift);
        kan_wide_t x;
        x = {sum[KAN_MAX_W-1], sum};
        if (shift != 8'd0) begin
            x = x + (kan_wide_t'(1) <<< (shift - 8'd1));
        end
        return x >>> shift;
    endfunction

    function automatic kan_wide_t kan_out_max(input int out_w);
        return (kan_wide_t'(1) <<< (out_w - 1)) - kan_wide_t'(1);
    endfunction

    function automatic logic kan_is_sat(input kan_wide_t x, input int out_w);
        return (x > kan_out_max(out_w)) || (x < ~kan_out_max(out_w));
    endfunction

    function automatic kan_wide_t kan_clip(input kan_wide_t x, input int out_w);
        kan_wide_t r;
        r = x;
        if (x > kan_out_max(out_w)) begin
            r = kan_out_max(out_w);
        end else if (x < ~kan_out_max(out_w)) begin
            r = ~kan_out_max(out_w);
        end
        return r;
    endfunction

endpackage

// File: rtl/kan_acc_ram.sv
// Simple dual-port accumulator RAM, one write port and one synchronous read port.
// Read data appears one cycle after an enabled read; read-before-write on address collision.
// No flow control of its own: the caller freezes it by dropping rd_en and wr_en.
module kan_acc_ram
    import kan_pkg::*;
#(
    parameter int WIDTH  = KAN_LANES * KAN_ACC_W,
    parameter int ADDR_W = KAN_LG_LAYERSIZE
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_dat
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/kan_mac_lanes.sv
// KAN layer MAC: activation x LANES coefficients per group, accumulated per group, quantised on the last term.
// Latency: 3 cycles from a final-term fire to m_axis_tvalid; one group per cycle when unstalled.
// Backpressure: a stalled output register freezes every stage, the counters and the RAM.
module kan_mac_lanes
    import kan_pkg::*;
#(
    parameter int DATA_W       = KAN_DATA_W,
    parameter int COEF_W       = KAN_COEF_W,
    parameter int LANES        = KAN_LANES,
    parameter int ACC_W        = KAN_ACC_W,
    parameter int OUT_W        = KAN_OUT_W,
    parameter int LG_LAYERSIZE = KAN_LG_LAYERSIZE,
    parameter int SHIFT_W      = KAN_SHIFT_W
) (
    input  logic                      s_axis_aclk,
    input  logic                      s_axis_aresetn,
    input  logic [DATA_W-1:0]         s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [LANES*COEF_W-1:0]   m_axi_rdata,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic [LANES*OUT_W-1:0]    m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    input  logic [LG_LAYERSIZE+2:0]   input_terms,
    input  logic [LG_LAYERSIZE:0]     output_groups,
    input  logic [SHIFT_W-1:0]        frac_shift,
    output logic                      busy,
    output logic                      overflow
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int TERM_W = LG_LAYERSIZE + 3;
    localparam int GRP_W  = LG_LAYERSIZE + 1;
    localparam int RAM_W  = LANES * ACC_W;

    logic                    run_q;
    logic                    active_q;
    logic                    busy_q;
    logic                    overflow_q;
    logic [TERM_W-1:0]       t_q;
    logic [LG_LAYERSIZE-1:0] g_q;
    logic [TERM_W-1:0]       terms_q;
    logic [GRP_W-1:0]        groups_q;
    logic [SHIFT_W-1:0]      shift_q;

    logic [TERM_W-1:0]       cur_terms;
    logic [GRP_W-1:0]        cur_groups;
    logic [SHIFT_W-1:0]      cur_shift;
    logic                    cfg_ok;
    logic                    en;
    logic                    fire;
    logic                    first_fire;
    logic                    g_last;
    logic                    t_last;
    logic                    active_nxt;
    logic                    tlast_hs;
    logic                    ov_set;
    kan_ctl_t                ctl_c;

    logic                    s1_vld;
    kan_ctl_t                s1_ctl;
    logic [LG_LAYERSIZE-1:0] s1_g;
    logic signed [PROD_W-1:0] s1_prod [LANES];
    logic signed [PROD_W-1:0] prod_c  [LANES];

    logic                    fwd_vld;
    logic [LG_LAYERSIZE-1:0] fwd_addr;
    logic [RAM_W-1:0]        fwd_dat;
    logic [RAM_W-1:0]        ram_rd;
    logic [RAM_W-1:0]        acc_rd;
    logic [RAM_W-1:0]        sum_bus;
    logic                    ram_we;

    logic                    s2_vld;
    logic                    s2_tlast;
    logic [7:0]              s2_shift;
    logic [ACC_W-1:0]        s2_sum [LANES];

    kan_wide_t               rs [LANES];
    logic [LANES-1:0]        sat;
    logic [LANES*OUT_W-1:0]  q_bus;

    // Config follows the ports while idle and is frozen by the first fire of a layer.
    always_comb begin
        cur_terms  = active_q ? terms_q  : input_terms;
        cur_groups = active_q ? groups_q : output_groups;
        cur_shift  = active_q ? shift_q  : frac_shift;
        cfg_ok     = active_q |
                     ((input_terms != '0) && (output_groups != '0) &&
                      (output_groups <= (GRP_W'(1) << LG_LAYERSIZE)));
        en         = ~m_axis_tvalid | m_axis_tready;
        fire       = run_q & en & s_axis_tvalid & m_axi_rvalid & cfg_ok;
        first_fire = fire & ~active_q;
        g_last     = ({1'b0, g_q} == (cur_groups - GRP_W'(1)));
        t_last     = (t_q == (cur_terms - TERM_W'(1)));
        active_nxt = fire ? ~(g_last & t_last) : active_q;
        tlast_hs   = m_axis_tvalid & m_axis_tready & m_axis_tlast;
        ov_set     = en & s2_vld & (|sat);

        ctl_c       = '0;
        ctl_c.first = (t_q == '0);
        ctl_c.fin   = t_last;
        ctl_c.tlast = t_last & g_last;
        ctl_c.shift = 8'(cur_shift);
    end

    assign m_axi_rready  = fire;
    assign s_axis_tready = fire & g_last;
    assign busy          = busy_q;
    assign overflow      = overflow_q;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            run_q      <= 1'b0;
            active_q   <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            t_q        <= '0;
            g_q        <= '0;
            terms_q    <= '0;
            groups_q   <= '0;
            shift_q    <= '0;
        end else begin
            run_q      <= 1'b1;
            active_q   <= active_nxt;
            busy_q     <= fire | active_nxt | (busy_q & ~tlast_hs);
            overflow_q <= (overflow_q & ~first_fire) | ov_set;
            if (first_fire) begin
                terms_q  <= input_terms;
                groups_q <= output_groups;
                shift_q  <= frac_shift;
            end
            if (fire) begin
                if (g_last) begin
                    g_q <= '0;
                    t_q <= t_last ? '0 : t_q + TERM_W'(1);
                end else begin
                    g_q <= g_q + LG_LAYERSIZE'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign prod_c[i] = PROD_W'($signed(s_axis_tdata)) *
                           PROD_W'($signed(m_axi_rdata[lane_lo(i, COEF_W) +: COEF_W]));
        assign sum_bus[lane_lo(i, ACC_W) +: ACC_W] =
            (s1_ctl.first ? ACC_W'(0) : acc_rd[lane_lo(i, ACC_W) +: ACC_W]) + ACC_W'(s1_prod[i]);
        assign rs[i]  = kan_round_shift({{(KAN_MAX_W-ACC_W){s2_sum[i][ACC_W-1]}}, s2_sum[i]}, s2_shift);
        assign sat[i] = kan_is_sat(rs[i], OUT_W);
        assign q_bus[lane_lo(i, OUT_W) +: OUT_W] = OUT_W'(kan_clip(rs[i], OUT_W));
    end

    // S1: products and RAM read are captured on the same edge.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            s1_vld <= 1'b0;
            s1_ctl <= '0;
            s1_g   <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_prod[i] <= '0;
            end
        end else if (en) begin
            s1_vld <= fire;
            if (fire) begin
                s1_ctl <= ctl_c;
                s1_g   <= g_q;
                for (int i = 0; i < LANES; i++) begin
                    s1_prod[i] <= prod_c[i];
                end
            end
        end
    end

    // The RAM read issued on the same edge as a write to that address returns the old word,
    // so the just-written sum is replayed from here (only possible with one group).
    assign acc_rd = (fwd_vld && (fwd_addr == s1_g)) ? fwd_dat : ram_rd;
    assign ram_we = en & s1_vld & ~s1_ctl.fin;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            fwd_vld  <= 1'b0;
            fwd_addr <= '0;
            fwd_dat  <= '0;
        end else if (en) begin
            fwd_vld  <= ram_we;
            fwd_addr <= s1_g;
            fwd_dat  <= sum_bus;
        end
    end

    kan_acc_ram #(
        .WIDTH  (RAM_W),
        .ADDR_W (LG_LAYERSIZE)
    ) u_acc_ram (
        .clk     (s_axis_aclk),
        .wr_en   (ram_we),
        .wr_addr (s1_g),
        .wr_dat  (sum_bus),
        .rd_en   (en),
        .rd_addr (g_q),
        .rd_dat  (ram_rd)
    );

    // S2: only final-term sums travel on; earlier terms live in the RAM.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            s2_vld   <= 1'b0;
            s2_tlast <= 1'b0;
            s2_shift <= '0;
            for (int i = 0; i < LANES; i++) begin
                s2_sum[i] <= '0;
            end
        end else if (en) begin
            s2_vld <= s1_vld & s1_ctl.fin;
            if (s1_vld && s1_ctl.fin) begin
                s2_tlast <= s1_ctl.tlast;
                s2_shift <= s1_ctl.shift;
                for (int i = 0; i < LANES; i++) begin
                    s2_sum[i] <= sum_bus[lane_lo(i, ACC_W) +: ACC_W];
                end
            end
        end
    end

    // S3: output register; data and tlast only move when a new beat enters.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (en) begin
            m_axis_tvalid <= s2_vld;
            if (s2_vld) begin
                m_axis_tdata <= q_bus;
                m_axis_tlast <= s2_tlast;
            end
        end
    end

endmodule

// File: tb/tb_kan_mac_lanes.sv
// Self-checking bench for kan_mac_lanes: directed layers plus randomized layers and handshakes
// checked against a plain-arithmetic model of the layer sums and quantisation.
module tb_kan_mac_lanes;

    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] m_axi_rdata;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [14:0] input_terms;
    logic [12:0] output_groups;
    logic [5:0]  frac_shift;
    logic        busy;
    logic        overflow;

    always #5 clk = ~clk;

    kan_mac_lanes dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axi_rdata    (m_axi_rdata),
        .m_axi_rvalid   (m_axi_rvalid),
        .m_axi_rready   (m_axi_rready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .input_terms    (input_terms),
        .output_groups  (output_groups),
        .frac_shift     (frac_shift),
        .busy           (busy),
        .overflow       (overflow)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] act_q [$];
    logic [63:0] coef_q [$];
    logic [64:0] exp_q [$];
    bit          exp_ov;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full dot product per group and lane, wrapped to 40 bits, then round/shift/clamp.
    task automatic build_exp(input int T, input int G, input int S);
        exp_q.delete();
        exp_ov = 0;
        for (int g = 0; g < G; g++) begin
            logic [63:0] bus;
            bus = '0;
            for (int l = 0; l < LANES; l++) begin
                longint s;
                s = 0;
                for (int t = 0; t < T; t++) begin
                    logic [63:0] cb;
                    logic [15:0] c16;
                    logic [15:0] a16;
                    cb  = coef_q[t*G + g];
                    c16 = cb[l*16 +: 16];
                    a16 = act_q[t];
                    s += longint'($signed(a16)) * longint'($signed(c16));
                end
                s = (s <<< 24) >>> 24;
                if (S > 0) s += longint'(1) <<< (S - 1);
                s = s >>> S;
                if (s > 32767) begin
                    s = 32767;
                    exp_ov = 1;
                end else if (s < -32768) begin
                    s = -32768;
                    exp_ov = 1;
                end
                bus[l*16 +: 16] = s[15:0];
            end
            exp_q.push_back({(g == G - 1), bus});
        end
    endtask

    task automatic fill_const(input int T, input int G, input logic [15:0] a, input logic [63:0] c);
        act_q.delete();
        coef_q.delete();
        for (int t = 0; t < T; t++) act_q.push_back(a);
        for (int k = 0; k < T*G; k++) coef_q.push_back(c);
    endtask

    task automatic fill_rand(input int T, input int G);
        act_q.delete();
        coef_q.delete();
        for (int t = 0; t < T; t++) act_q.push_back(16'($urandom));
        for (int k = 0; k < T*G; k++) coef_q.push_back({$urandom, $urandom});
    endtask

    task automatic run_layer(input string tag, input int T, input int G, input int S,
                             input int vpct, input int rpct, input int stall_beat, input bit scramble);
        int ai, ci, oi, cyc, stall;
        bit a_tk, c_tk, hold, do_scr, extra;
        logic [65:0] hold_d;
        build_exp(T, G, S);
        @(negedge clk);
        input_terms   = 15'(T);
        output_groups = 13'(G);
        frac_shift    = 6'(S);
        s_axis_tvalid = 0;
        m_axi_rvalid  = 0;
        ai = 0; ci = 0; oi = 0; cyc = 0; stall = 0;
        a_tk = 0; c_tk = 0; hold = 0; do_scr = 0;
        hold_d = '0;
        while (oi < G && cyc < 4000) begin
            if (do_scr) begin
                input_terms   = 15'($urandom);
                output_groups = 13'($urandom);
                frac_shift    = 6'($urandom);
                do_scr = 0;
            end
            if (a_tk) s_axis_tvalid = 0;
            if (c_tk) m_axi_rvalid = 0;
            if (!s_axis_tvalid && ai < T && $urandom_range(99) < vpct) s_axis_tvalid = 1;
            if (!m_axi_rvalid && ci < T*G && $urandom_range(99) < vpct) m_axi_rvalid = 1;
            if (ai < T) s_axis_tdata = act_q[ai];
            if (ci < T*G) m_axi_rdata = coef_q[ci];
            if (stall > 0) begin
                m_axis_tready = 0;
                stall--;
            end else begin
                m_axis_tready = ($urandom_range(99) < rpct);
            end
            #1;
            if (hold) chk({tag, " held_beat"}, {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, hold_d);
            if (m_axis_tvalid && !m_axis_tready)
                chk({tag, " stall_readys"}, {s_axis_tready, m_axi_rready}, 2'b00);
            if (m_axis_tvalid && m_axis_tready) begin
                if (oi < G) chk($sformatf("%s beat%0d", tag, oi), {m_axis_tlast, m_axis_tdata}, exp_q[oi]);
                oi++;
                if (oi == stall_beat) stall = 10;
            end
            hold   = m_axis_tvalid && !m_axis_tready;
            hold_d = {1'b1, m_axis_tlast, m_axis_tdata};
            a_tk   = s_axis_tvalid && s_axis_tready;
            c_tk   = m_axi_rvalid && m_axi_rready;
            if (a_tk) ai++;
            if (c_tk) begin
                ci++;
                if (scramble && ci == 1) do_scr = 1;
            end
            cyc++;
            @(negedge clk);
        end
        chk({tag, " completed"}, {oi == G, ai == T, ci == T*G}, 3'b111);
        s_axis_tvalid = 0;
        m_axi_rvalid  = 0;
        m_axis_tready = 1;
        #1;
        chk({tag, " busy_after"}, busy, 1'b0);
        chk({tag, " overflow"}, overflow, exp_ov);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            extra |= m_axis_tvalid;
        end
        chk({tag, " no_extra_beat"}, extra, 1'b0);
    endtask

    initial begin
        rst_n         = 0;
        s_axis_tdata  = 16'h1234;
        s_axis_tvalid = 1;
        m_axi_rdata   = 64'h0001_0001_0001_0001;
        m_axi_rvalid  = 1;
        m_axis_tready = 1;
        input_terms   = 15'd2;
        output_groups = 13'd2;
        frac_shift    = 6'd0;

        #22;
        chk("reset outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, overflow,
                              s_axis_tready, m_axi_rready}, '0);
        @(negedge clk);
        s_axis_tvalid = 0;
        m_axi_rvalid  = 0;
        rst_n = 1;
        @(negedge clk);

        // Zero counts keep the block idle.
        s_axis_tvalid = 1;
        m_axi_rvalid  = 1;
        input_terms   = 15'd0;
        output_groups = 13'd3;
        repeat (3) begin
            @(negedge clk);
            #1 chk("zero_terms idle", {s_axis_tready, m_axi_rready, busy}, 3'b000);
        end
        input_terms   = 15'd3;
        output_groups = 13'd0;
        @(negedge clk);
        #1 chk("zero_groups idle", {s_axis_tready, m_axi_rready, busy}, 3'b000);
        s_axis_tvalid = 0;
        m_axi_rvalid  = 0;

        act_q.delete();
        coef_q.delete();
        act_q.push_back(16'd2);
        act_q.push_back(16'd3);
        repeat (3) coef_q.push_back(64'h0100_0100_0100_0100);
        repeat (3) coef_q.push_back(64'h0200_0200_0200_0200);
        run_layer("acc_scale", 2, 3, 8, 100, 100, -1, 0);

        fill_const(4, 2, 16'h7FFF, 64'h7FFF_7FFF_7FFF_7FFF);
        run_layer("saturate", 4, 2, 0, 100, 100, -1, 0);

        fill_const(1, 1, 16'hFFFF, 64'h0001_0001_0001_0001);
        run_layer("neg_one", 1, 1, 0, 100, 100, -1, 0);

        fill_const(1, 1, 16'd384, 64'hFFFF_0001_FFFF_0001);
        run_layer("rounding", 1, 1, 8, 100, 100, -1, 0);

        fill_const(5, 1, 16'd1, 64'h0001_0001_0001_0001);
        run_layer("forward", 5, 1, 0, 100, 100, -1, 0);

        fill_rand(3, 4);
        run_layer("backpressure", 3, 4, 10, 100, 100, 1, 0);

        fill_rand(6, 1);
        run_layer("fwd_gaps", 6, 1, 4, 60, 70, -1, 1);

        for (int n = 0; n < 6; n++) begin
            int T, G, S;
            T = $urandom_range(1, 6);
            G = $urandom_range(1, 5);
            S = $urandom_range(0, 24);
            fill_rand(T, G);
            run_layer($sformatf("rand%0d", n), T, G, S, $urandom_range(40, 100),
                      $urandom_range(30, 100), -1, 1);
        end

        // Abort a layer part-way with reset, then run a clean layer.
        @(negedge clk);
        input_terms   = 15'd3;
        output_groups = 13'd2;
        frac_shift    = 6'd2;
        s_axis_tdata  = 16'h7FFF;
        m_axi_rdata   = 64'h7FFF_7FFF_7FFF_7FFF;
        s_axis_tvalid = 1;
        m_axi_rvalid  = 1;
        m_axis_tready = 1;
        repeat (4) @(negedge clk);
        #1 chk("busy before abort", busy, 1'b1);
        rst_n = 0;
        #1 chk("abort outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, overflow,
                                 s_axis_tready, m_axi_rready}, '0);
        @(negedge clk);
        s_axis_tvalid = 0;
        m_axi_rvalid  = 0;
        rst_n = 1;
        fill_rand(3, 2);
        run_layer("after_abort", 3, 2, 6, 80, 80, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kan_mac_lanes.md
# kan_mac_lanes

Parametrised multiply-accumulate engine for one KAN layer. It sits between the activation stream (AXI-Stream slave), the coefficient read-data channel (AXI read-data slave side) and the result stream (AXI-Stream master). For every input term it multiplies one signed activation against `LANES` signed coefficients per output group and accumulates into an on-chip accumulator RAM. On the final term it rounds, shifts and saturates the sums and streams them out with full backpressure.

## Interface
Reset is asynchronous and active-low. The block has one clock.

Parameters:
- `DATA_W`, 16: signed activation width.
- `COEF_W`, 16: signed coefficient width per lane.
- `LANES`, 4: parallel output lanes per group.
- `ACC_W`, 40: signed accumulator width per lane.
- `OUT_W`, 16: signed output width per lane.
- `LG_LAYERSIZE`, 12: log2 of the accumulator depth in groups.
- `SHIFT_W`, 6: width of `frac_shift`.

Ports:
- `s_axis_aclk` in 1: clock.
- `s_axis_aresetn` in 1: asynchronous active-low reset.
- `s_axis_tdata` in `DATA_W`: activation. `s_axis_tvalid` in 1. `s_axis_tready` out 1.
- `m_axi_rdata` in `LANES*COEF_W`: coefficients; lane i is at `[i*COEF_W +: COEF_W]`. `m_axi_rvalid` in 1. `m_axi_rready` out 1.
- `m_axis_tdata` out `LANES*OUT_W`: results; lane i is at `[i*OUT_W +: OUT_W]`. `m_axis_tvalid` out 1. `m_axis_tlast` out 1. `m_axis_tready` in 1.
- `input_terms` in `LG_LAYERSIZE+3`: number of terms per layer.
- `output_groups` in `LG_LAYERSIZE+1`: groups per term. Maximum is 2^`LG_LAYERSIZE`.
- `frac_shift` in `SHIFT_W`: arithmetic right shift applied at output.
- `busy` out 1: layer in progress.
- `overflow` out 1: sticky flag, set when any output lane saturated during the current layer.

## Operation
- **Config latch.** Config is latched on the first accepted beat while idle. If either count is 0, the block stays idle and never asserts ready.
- **Counters.** The term counter `t` and group counter `g` both start at 0.
- **Fire condition.** `fire = en & s_axis_tvalid & m_axi_rvalid & cfg_ok`, where `en = ~m_axis_tvalid | m_axis_tready`.
- **Ready outputs.**
  - `m_axi_rready = fire`.
  - `s_axis_tready = fire & (g == groups-1)`: the activation is held across all groups.
- **Counter advance.** On fire, g increments. At g wrap, t increments. At t wrap, the layer ends.
- **Per-lane arithmetic.**
  - Each product is signed `DATA_W+COEF_W`, sign-extended to `ACC_W`.
  - New sum = (t==0 ? 0 : acc[g][lane]) + product.
  - The accumulator wraps modulo 2^`ACC_W`.
- **Writeback.** The sum is written to acc[g] unless t == terms-1.
- **Final term output.** On the last term, each lane is processed in order:
  - If shift > 0, add 2^(shift-1) (round half up).
  - Arithmetic right shift by `frac_shift`.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. On saturation, set `overflow`.
  - The result is placed in the output register.
- **tlast.** `m_axis_tlast` is asserted on the beat with g == groups-1 of the last term.
- **busy.** Set on the first fire. Cleared on the handshake of the tlast beat.
- **overflow.** Cleared on the first fire of a new layer.
- **Read-after-write hazard.** When groups == 1, the S1 read address equals the S2 write address. S2 write data is forwarded in place of the RAM read data. For groups ≥ 2, ordering guarantees the RAM already holds the value.

## Timing
- **Pipeline.**
  - S1: register the products; issue the RAM read (1-cycle synchronous).
  - S2: add and write.
  - S3: quantise into the output register.
- **Latency.** 3 cycles from a final-term fire to `m_axis_tvalid`.
- **Throughput.** One group per cycle with no backpressure.
- **Stall.** When `en == 0`, all stages, counters and the RAM write enable freeze. `m_axis_tdata` and `m_axis_tlast` are held stable while tvalid is high and tready is low.
- **Intermediate terms.** These produce no output beats; non-final terms never set tvalid.
- **Layer chaining.** The next layer's fire may occur in the cycle after the last fire of the previous layer. t==0 ignores stale RAM contents.
- **Reset.**
  - Reset values: all outputs 0; pipeline valids, counters and flags cleared.
  - Reset mid-layer aborts the layer. RAM contents are don't-care.

## Structure
- Package `kan_pkg` holds:
  - lane slicing helpers;
  - the round/shift/saturate function;
  - default width constants shared with the layer controller.
- Sub-module `kan_acc_ram`: simple dual-port, `LANES*ACC_W` wide, 2^`LG_LAYERSIZE` deep, synchronous read, read-enable tied to `en`.

## Test plan
- **Accumulate and scale.** terms=2, groups=3, shift=8, activations 2 then 3, all coefficients 0x0100 then 0x0200 -> 3 beats, every lane = 8, tlast on the 3rd, overflow=0.
- **Saturation and sign.**
  - act 0x7FFF, coef 0x7FFF, terms=4, shift=0 -> lanes 0x7FFF, overflow=1.
  - act -1, coef 1, terms=1 -> lanes 0xFFFF.
- **Rounding.** Sum 384, shift=8 -> 2. Sum -384, shift=8 -> -1.
- **Forwarding.** groups=1, terms=5, act=1, coef=1 every lane, valids continuous -> single beat, value 5, tlast=1.
- **Backpressure.** tready low 10 cycles mid-output -> no rready/tready pulses, tdata stable, no beats lost or duplicated. Random valid/ready gaps match the reference model.
- **Reset mid-layer.** Reset mid-layer -> all outputs 0, busy=0. The next layer computes correctly from t=0.
